// File: rtl/iob_iob2axil_pkg.sv
// ============================================================================
// Module : iob_iob2axil_pkg
// Brief  : Shared FSM encoding and AXI-Lite constants for the IOb-to-AXI-Lite bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package iob_iob2axil_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    WAIT_B = 3'd2,
    RD     = 3'd3,
    WAIT_R = 3'd4
  } state_t;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

endpackage

`default_nettype wire

// File: rtl/iob_iob2axil_if.sv
// ============================================================================
// Module : iob_iob2axil_if
// Brief  : IOb request/response and AXI-Lite manager signals of the bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface iob_iob2axil_if #(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
);
  logic                     iob_valid_i;
  logic [ADDR_W-1:0]        iob_addr_i;
  logic [DATA_W-1:0]        iob_wdata_i;
  logic [DATA_W/8-1:0]      iob_wstrb_i;
  logic                     iob_ready_o;
  logic                     iob_rvalid_o;
  logic [DATA_W-1:0]        iob_rdata_o;

  logic [AXIL_ADDR_W-1:0]   axil_awaddr_o;
  logic [2:0]               axil_awprot_o;
  logic                     axil_awvalid_o;
  logic                     axil_awready_i;
  logic [AXIL_DATA_W-1:0]   axil_wdata_o;
  logic [AXIL_DATA_W/8-1:0] axil_wstrb_o;
  logic                     axil_wvalid_o;
  logic                     axil_wready_i;
  logic [1:0]               axil_bresp_i;
  logic                     axil_bvalid_i;
  logic                     axil_bready_o;
  logic [AXIL_ADDR_W-1:0]   axil_araddr_o;
  logic [2:0]               axil_arprot_o;
  logic                     axil_arvalid_o;
  logic                     axil_arready_i;
  logic [AXIL_DATA_W-1:0]   axil_rdata_i;
  logic [1:0]               axil_rresp_i;
  logic                     axil_rvalid_i;
  logic                     axil_rready_o;

  // Bridge side: IOb subordinate and AXI-Lite manager.
  modport master (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rvalid_o, iob_rdata_o,
    output axil_awaddr_o, axil_awprot_o, axil_awvalid_o, input axil_awready_i,
    output axil_wdata_o, axil_wstrb_o, axil_wvalid_o, input axil_wready_i,
    input  axil_bresp_i, axil_bvalid_i, output axil_bready_o,
    output axil_araddr_o, axil_arprot_o, axil_arvalid_o, input axil_arready_i,
    input  axil_rdata_i, axil_rresp_i, axil_rvalid_i, output axil_rready_o
  );

  // Environment side: IOb core plus AXI-Lite subordinate.
  modport slave (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rvalid_o, iob_rdata_o,
    input  axil_awaddr_o, axil_awprot_o, axil_awvalid_o, output axil_awready_i,
    input  axil_wdata_o, axil_wstrb_o, axil_wvalid_o, output axil_wready_i,
    output axil_bresp_i, axil_bvalid_i, input axil_bready_o,
    input  axil_araddr_o, axil_arprot_o, axil_arvalid_o, output axil_arready_i,
    output axil_rdata_i, axil_rresp_i, axil_rvalid_i, input axil_rready_o
  );
endinterface

`default_nettype wire

// File: rtl/iob_iob2axil_wch.sv
// ============================================================================
// Module : iob_iob2axil_wch
// Brief  : AW/W dual-handshake tracker; each channel completes independently.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iob_iob2axil_wch (
  input  wire logic clk_i,
  input  wire logic cke_i,
  input  wire logic arst_i,
  input  wire logic start,
  input  wire logic awready,
  input  wire logic wready,
  output logic      awvalid,
  output logic      wvalid,
  output logic      both_done
);

  logic aw_done;
  logic w_done;
  logic aw_done_nxt;
  logic w_done_nxt;
  logic aw_fire;
  logic w_fire;

  // Valids depend only on state and registered flags, never on the readies.
  assign awvalid   = start & ~aw_done;
  assign wvalid    = start & ~w_done;
  assign aw_fire   = awvalid & awready;
  assign w_fire    = wvalid & wready;
  assign both_done = (aw_done | aw_fire) & (w_done | w_fire);

  assign aw_done_nxt = both_done ? 1'b0 : (aw_done | aw_fire);
  assign w_done_nxt  = both_done ? 1'b0 : (w_done | w_fire);

  iob_reg #(.DATA_W(1)) u_aw_done_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i),
    .data_i(aw_done_nxt), .data_o(aw_done)
  );

  iob_reg #(.DATA_W(1)) u_w_done_reg (
    .clk_i (clk_i), .cke_i (cke_i), .arst_i (arst_i),
    .data_i(w_done_nxt), .data_o(w_done)
  );

endmodule

`default_nettype wire

// File: rtl/iob_reg.sv
// ============================================================================
// Module : iob_reg
// Brief  : Clock-enabled register with asynchronous active-high reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iob_reg #(
  parameter int               DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  wire logic              clk_i,
  input  wire logic              cke_i,
  input  wire logic              arst_i,
  input  wire logic [DATA_W-1:0] data_i,
  output logic      [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_iob2axil.sv
// ============================================================================
// Module : iob_iob2axil
// Brief  : IOb subordinate to AXI-Lite manager bridge, one transaction in flight.
//          Optional sticky response-error flag: IOB_IOB2AXIL_RESP_ERR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module iob_iob2axil
  import iob_iob2axil_pkg::*;
#(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
) (
  input  wire logic      clk_i,
  input  wire logic      cke_i,
  input  wire logic      arst_i,
  iob_iob2axil_if.master bus
`ifdef IOB_IOB2AXIL_RESP_ERR_EN
  ,
  output logic           err_o,
  input  wire logic      err_clr_i
`endif
);

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              state_q;
  logic                    accept;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     wstrb_q;
  logic [AXIL_ADDR_W-1:0]  axil_addr;
  logic                    both_done;
  logic                    bready;
  logic                    rready;
  logic                    r_fire;

  assign state  = state_t'(state_q);
  assign accept = (state == IDLE) & bus.iob_valid_i;
  // Readies are gated so no handshake can complete while state is frozen.
  assign bready = cke_i & (state == WAIT_B);
  assign rready = cke_i & (state == WAIT_R);
  assign r_fire = bus.axil_rvalid_i & rready;

  assign bus.iob_ready_o = cke_i & (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.iob_valid_i) state_nxt = (|bus.iob_wstrb_i) ? WR : RD;
      WR:      if (both_done) state_nxt = WAIT_B;
      WAIT_B:  if (bus.axil_bvalid_i) state_nxt = IDLE;
      RD:      if (bus.axil_arready_i) state_nxt = WAIT_R;
      WAIT_R:  if (bus.axil_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  iob_reg #(.DATA_W(3)) u_state_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(state_nxt), .data_o(state_q)
  );

  iob_reg #(.DATA_W(ADDR_W)) u_addr_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(accept ? bus.iob_addr_i : addr_q), .data_o(addr_q)
  );

  iob_reg #(.DATA_W(DATA_W)) u_wdata_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(accept ? bus.iob_wdata_i : wdata_q), .data_o(wdata_q)
  );

  iob_reg #(.DATA_W(DATA_W/8)) u_wstrb_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(accept ? bus.iob_wstrb_i : wstrb_q), .data_o(wstrb_q)
  );

  iob_reg #(.DATA_W(DATA_W)) u_rdata_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(r_fire ? bus.axil_rdata_i : bus.iob_rdata_o), .data_o(bus.iob_rdata_o)
  );

  iob_reg #(.DATA_W(1)) u_rvalid_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(r_fire), .data_o(bus.iob_rvalid_o)
  );

  iob_iob2axil_wch u_wch (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .arst_i   (arst_i),
    .start    (state == WR),
    .awready  (bus.axil_awready_i),
    .wready   (bus.axil_wready_i),
    .awvalid  (bus.axil_awvalid_o),
    .wvalid   (bus.axil_wvalid_o),
    .both_done(both_done)
  );

  generate
    if (ADDR_W >= AXIL_ADDR_W) begin : g_addr_trunc
      assign axil_addr = addr_q[AXIL_ADDR_W-1:0];
      if (ADDR_W > AXIL_ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_q[ADDR_W-1:AXIL_ADDR_W];
      end
    end else begin : g_addr_zext
      assign axil_addr = {{(AXIL_ADDR_W-ADDR_W){1'b0}}, addr_q};
    end
  endgenerate

  assign bus.axil_awaddr_o  = axil_addr;
  assign bus.axil_awprot_o  = AXI_PROT_DEFAULT;
  assign bus.axil_wdata_o   = wdata_q;
  assign bus.axil_wstrb_o   = wstrb_q;
  assign bus.axil_bready_o  = bready;
  assign bus.axil_araddr_o  = axil_addr;
  assign bus.axil_arprot_o  = AXI_PROT_DEFAULT;
  assign bus.axil_arvalid_o = (state == RD);
  assign bus.axil_rready_o  = rready;

`ifdef IOB_IOB2AXIL_RESP_ERR_EN
  logic err_set;
  logic err_nxt;

  // SLVERR and DECERR both have resp[1] set; set dominates a same-cycle clear.
  assign err_set = (bus.axil_bvalid_i & bready & bus.axil_bresp_i[1]) |
                   (r_fire & bus.axil_rresp_i[1]);
  assign err_nxt = err_set | (err_o & ~err_clr_i);

  iob_reg #(.DATA_W(1)) u_err_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(err_nxt), .data_o(err_o)
  );
`else
  logic unused_resp;
  assign unused_resp = ^{bus.axil_bresp_i, bus.axil_rresp_i};
`endif

endmodule

`default_nettype wire
